// File: rtl/sound_pkg.sv
// sound_pkg: shared APU channel constants (length-field widths, NRx4 bit positions).
package sound_pkg;
   localparam int WIDTH_SQ    = 6;
   localparam int WIDTH_WAVE  = 8;
   localparam int WIDTH_NOISE = 6;
   localparam int LEN_EN_BIT  = 6;
   localparam int TRIG_BIT    = 7;
endpackage

// File: rtl/sound_length_timer.sv
// sound_length_timer: per-channel APU length counter with NRx1/NRx4 write semantics,
// DMG/CGB extra-clock and trigger-reload quirks, and DAC-off kill.
module sound_length_timer
   import sound_pkg::*;
#(
   parameter int WIDTH        = WIDTH_SQ,
   parameter bit EXTRA_CLK_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_len,
   input  logic             len_phase,
   input  logic             len_wr,
   input  logic [WIDTH-1:0] len_data,
   input  logic             ctrl_wr,
   input  logic             ctrl_len_en,
   input  logic             ctrl_trigger,
   input  logic             dac_en,
   output logic             enable,
   output logic [WIDTH:0]   length_left
);
   localparam logic [WIDTH:0] MAX = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
   logic [WIDTH:0] cnt, cnt_nx;
   logic           len_en, len_en_nx, enable_nx;
   // Each step sees the result of the one before it; later steps win.
   always_comb begin
      cnt_nx    = cnt;
      enable_nx = enable;
      len_en_nx = len_en;
      if (tick_len && len_en && cnt_nx != '0) begin
         cnt_nx = cnt_nx - ONE;
         if (cnt_nx == '0) enable_nx = 1'b0;
      end
      if (len_wr) cnt_nx = MAX - {1'b0, len_data};
      if (ctrl_wr) len_en_nx = ctrl_len_en;
      // Enabling length during a non-clocking phase steals one count immediately.
      if (EXTRA_CLK_EN && ctrl_wr && !len_en && ctrl_len_en && len_phase && cnt_nx != '0) begin
         cnt_nx = cnt_nx - ONE;
         if (cnt_nx == '0 && !ctrl_trigger) enable_nx = 1'b0;
      end
      if (ctrl_wr && ctrl_trigger) begin
         enable_nx = dac_en;
         if (cnt_nx == '0) cnt_nx = (EXTRA_CLK_EN && ctrl_len_en && len_phase) ? MAX - ONE : MAX;
      end
      if (!dac_en) enable_nx = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         len_en <= 1'b0;
         enable <= 1'b0;
      end else begin
         cnt    <= cnt_nx;
         len_en <= len_en_nx;
         enable <= enable_nx;
      end
   end
   assign length_left = cnt;
endmodule

// File: tb/tb_sound_length_timer.sv
// tb_sound_length_timer: three timer variants (6-bit quirky, 6-bit plain, 8-bit quirky)
// driven in lockstep and checked against an integer reference model.
module tb_sound_length_timer;
   import sound_pkg::*;
   logic       clk = 1'b0, rst = 1'b1;
   logic       tick_len = 0, len_phase = 0, len_wr = 0, ctrl_wr = 0;
   logic       ctrl_len_en = 0, ctrl_trigger = 0, dac_en = 1;
   logic [7:0] len_data = 0, nrx4;
   logic       en0, en1, en2;
   logic [6:0] ll0, ll1;
   logic [8:0] ll2;
   int         tests = 0, fails = 0;
   int         w[3]   = '{6, 6, 8};
   bit         ext[3] = '{1'b1, 1'b0, 1'b1};
   int         m_cnt[3];
   bit         m_en[3], m_le[3];

   always #5 clk = ~clk;

   sound_length_timer #(.WIDTH(WIDTH_SQ), .EXTRA_CLK_EN(1'b1)) u0 (
      .clk(clk), .rst(rst), .tick_len(tick_len), .len_phase(len_phase), .len_wr(len_wr),
      .len_data(len_data[5:0]), .ctrl_wr(ctrl_wr), .ctrl_len_en(ctrl_len_en),
      .ctrl_trigger(ctrl_trigger), .dac_en(dac_en), .enable(en0), .length_left(ll0));
   sound_length_timer #(.WIDTH(WIDTH_NOISE), .EXTRA_CLK_EN(1'b0)) u1 (
      .clk(clk), .rst(rst), .tick_len(tick_len), .len_phase(len_phase), .len_wr(len_wr),
      .len_data(len_data[5:0]), .ctrl_wr(ctrl_wr), .ctrl_len_en(ctrl_len_en),
      .ctrl_trigger(ctrl_trigger), .dac_en(dac_en), .enable(en1), .length_left(ll1));
   sound_length_timer #(.WIDTH(WIDTH_WAVE), .EXTRA_CLK_EN(1'b1)) u2 (
      .clk(clk), .rst(rst), .tick_len(tick_len), .len_phase(len_phase), .len_wr(len_wr),
      .len_data(len_data), .ctrl_wr(ctrl_wr), .ctrl_len_en(ctrl_len_en),
      .ctrl_trigger(ctrl_trigger), .dac_en(dac_en), .enable(en2), .length_left(ll2));

   function automatic void mreset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_en[i]  = 0;
         m_le[i]  = 0;
      end
   endfunction

   function automatic void mstep(int i);
      int mx = 1 << w[i];
      int c  = m_cnt[i];
      bit e  = m_en[i];
      if (tick_len && m_le[i] && c > 0) begin
         c--;
         if (c == 0) e = 0;
      end
      if (len_wr) c = mx - (int'(len_data) % mx);
      if (ext[i] && ctrl_wr && !m_le[i] && ctrl_len_en && len_phase && c > 0) begin
         c--;
         if (c == 0 && !ctrl_trigger) e = 0;
      end
      if (ctrl_wr) m_le[i] = ctrl_len_en;
      if (ctrl_wr && ctrl_trigger) begin
         e = dac_en;
         if (c == 0) c = (ext[i] && ctrl_len_en && len_phase) ? mx - 1 : mx;
      end
      if (!dac_en) e = 0;
      m_cnt[i] = c;
      m_en[i]  = e;
   endfunction

   task automatic chk(string tag, int got, int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_all();
      chk("u0.enable", int'(en0), int'(m_en[0]));
      chk("u0.length_left", int'(ll0), m_cnt[0]);
      chk("u1.enable", int'(en1), int'(m_en[1]));
      chk("u1.length_left", int'(ll1), m_cnt[1]);
      chk("u2.enable", int'(en2), int'(m_en[2]));
      chk("u2.length_left", int'(ll2), m_cnt[2]);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst) mreset();
      else for (int i = 0; i < 3; i++) mstep(i);
      #1;
      chk_all();
      tick_len = 0;
      len_wr   = 0;
      ctrl_wr  = 0;
   endtask

   task automatic wr_len(int d);
      len_data = 8'(d);
      len_wr   = 1;
      cyc();
   endtask

   task automatic wr_ctrl(bit le, bit tr, bit ph);
      ctrl_len_en  = le;
      ctrl_trigger = tr;
      len_phase    = ph;
      ctrl_wr      = 1;
      cyc();
   endtask

   initial begin
      mreset();
      cyc();
      cyc();
      chk("reset.ll0", int'(ll0), 0);
      chk("reset.en0", int'(en0), 0);
      rst = 0;
      // basic countdown
      wr_len(60);
      chk("t1.load", int'(ll0), 4);
      wr_ctrl(1, 1, 0);
      chk("t1.enable", int'(en0), 1);
      for (int k = 3; k >= 0; k--) begin
         tick_len = 1;
         cyc();
         chk("t1.count", int'(ll0), k);
      end
      chk("t1.expired", int'(en0), 0);
      // trigger reload from zero
      wr_ctrl(1, 1, 1);
      chk("t2.reload_quirk", int'(ll0), 63);
      chk("t2.reload_plain", int'(ll1), 64);
      chk("t2.enable", int'(en0), 1);
      wr_len(63);
      tick_len = 1;
      cyc();
      chk("t2.zero", int'(ll0), 0);
      wr_ctrl(1, 1, 0);
      chk("t2.reload_full", int'(ll0), 64);
      // extra clock on length enable
      wr_ctrl(0, 0, 0);
      wr_len(54);
      wr_ctrl(1, 0, 1);
      chk("t3.extra", int'(ll0), 9);
      chk("t3.no_extra", int'(ll1), 10);
      wr_ctrl(0, 0, 0);
      wr_len(63);
      wr_ctrl(1, 0, 1);
      chk("t3.extra_zero", int'(ll0), 0);
      chk("t3.extra_kill", int'(en0), 0);
      chk("t3.plain_cnt", int'(ll1), 1);
      wr_ctrl(0, 0, 0);
      wr_len(63);
      wr_ctrl(1, 1, 1);
      chk("t3.extra_trig_cnt", int'(ll0), 63);
      chk("t3.extra_trig_en", int'(en0), 1);
      chk("t3.plain_trig_cnt", int'(ll1), 1);
      // 8-bit full length, length disabled
      wr_len(0);
      chk("t4.load256", int'(ll2), 256);
      wr_ctrl(0, 0, 0);
      for (int k = 0; k < 300; k++) begin
         tick_len  = 1;
         len_phase = 1'($urandom);
         cyc();
      end
      chk("t4.hold256", int'(ll2), 256);
      // len_wr beats tick, DAC kill
      wr_ctrl(1, 0, 0);
      wr_len(44);
      chk("t5.cnt20", int'(ll0), 20);
      tick_len = 1;
      wr_len(50);
      chk("t5.wr_wins", int'(ll0), 14);
      dac_en = 0;
      cyc();
      chk("t5.dac_off", int'(en0), 0);
      wr_ctrl(1, 1, 0);
      chk("t5.trig_dac_off", int'(en0), 0);
      dac_en = 1;
      wr_ctrl(1, 1, 0);
      chk("t5.trig_en", int'(en0), 1);
      chk("t5.no_reload", int'(ll0), 14);
      dac_en = 0;
      cyc();
      chk("t5.dac_drop", int'(en0), 0);
      dac_en = 1;
      // asynchronous reset mid-count
      wr_len(34);
      wr_ctrl(1, 1, 0);
      chk("t6.pre_cnt", int'(ll0), 30);
      chk("t6.pre_en", int'(en0), 1);
      rst = 1;
      #2;
      mreset();
      chk("t6.async_cnt", int'(ll0), 0);
      chk("t6.async_en", int'(en0), 0);
      cyc();
      rst = 0;
      tick_len = 1;
      cyc();
      chk("t6.post_tick", int'(ll0), 0);
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         rst          = ($urandom % 150) == 0;
         tick_len     = ($urandom % 4) == 0;
         len_phase    = 1'($urandom);
         len_wr       = ($urandom % 8) == 0;
         len_data     = 8'($urandom);
         nrx4         = 8'($urandom);
         ctrl_wr      = ($urandom % 6) == 0;
         ctrl_len_en  = nrx4[LEN_EN_BIT];
         ctrl_trigger = nrx4[TRIG_BIT];
         dac_en       = ($urandom % 12) != 0;
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
